// File: rtl/circuit1_seq_ctrl.sv
// Multicycle circuit1: z = max(a+b, a+c), x = a*c - (a+b), sequenced over four
// cycles on one shared add/sub ALU, one multiplier and one comparator.
module circuit1_seq_ctrl #(
  parameter int DATAWIDTH = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Start,
  input  logic [DATAWIDTH-1:0]     a,
  input  logic [DATAWIDTH-1:0]     b,
  input  logic [DATAWIDTH-1:0]     c,
  output logic [DATAWIDTH-1:0]     z,
  output logic [2*DATAWIDTH-1:0]   x,
  output logic                     Done,
  output logic                     Busy
);

  localparam int W2 = 2 * DATAWIDTH;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATAWIDTH-1:0]  ra_q, ra_d;
  logic [DATAWIDTH-1:0]  rb_q, rb_d;
  logic [DATAWIDTH-1:0]  rc_q, rc_d;
  logic [DATAWIDTH-1:0]  d_q, d_d;
  logic [DATAWIDTH-1:0]  e_q, e_d;
  logic [W2-1:0]         f_q, f_d;
  logic [DATAWIDTH-1:0]  z_q, z_d;
  logic [W2-1:0]         x_q, x_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  // Shared datapath resources; the FSM steers their operands per state.
  logic [W2-1:0]         alu_a, alu_b, alu_y;
  logic                  alu_sub;
  logic [W2-1:0]         mul_y;
  logic                  cmp_gt;

  assign alu_y  = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
  assign mul_y  = {{DATAWIDTH{1'b0}}, ra_q} * {{DATAWIDTH{1'b0}}, rc_q};
  assign cmp_gt = (d_q > e_q);

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    d_d     = d_q;
    e_d     = e_q;
    f_d     = f_q;
    z_d     = z_q;
    x_d     = x_q;
    alu_a   = '0;
    alu_b   = '0;
    alu_sub = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          ra_d    = a;
          rb_d    = b;
          rc_d    = c;
          state_d = S1;
        end
      end
      S1: begin
        alu_a   = {{DATAWIDTH{1'b0}}, ra_q};
        alu_b   = {{DATAWIDTH{1'b0}}, rb_q};
        d_d     = alu_y[DATAWIDTH-1:0];
        f_d     = mul_y;
        state_d = S2;
      end
      S2: begin
        alu_a   = {{DATAWIDTH{1'b0}}, ra_q};
        alu_b   = {{DATAWIDTH{1'b0}}, rc_q};
        e_d     = alu_y[DATAWIDTH-1:0];
        state_d = S3;
      end
      S3: begin
        // Product minus the truncated sum; underflow simply wraps.
        alu_a   = f_q;
        alu_b   = {{DATAWIDTH{1'b0}}, d_q};
        alu_sub = 1'b1;
        x_d     = alu_y;
        z_d     = cmp_gt ? d_q : e_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they track the state register exactly.
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      d_q     <= '0;
      e_q     <= '0;
      f_q     <= '0;
      z_q     <= '0;
      x_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      d_q     <= d_d;
      e_q     <= e_d;
      f_q     <= f_d;
      z_q     <= z_d;
      x_q     <= x_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign z    = z_q;
  assign x    = x_q;
  assign Done = done_q;
  assign Busy = busy_q;

endmodule

// File: tb/tb_circuit1_seq_ctrl.sv
// Directed bench for circuit1_seq_ctrl: a job table plus hand-written
// sequences for reset, back-to-back, ignored Start and mid-job reset.
module tb_circuit1_seq_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [7:0]  a = '0, b = '0, c = '0;
  logic [7:0]  z;
  logic [15:0] x;
  logic        Done, Busy;

  int n_checks = 0;
  int n_pass   = 0;

  circuit1_seq_ctrl #(.DATAWIDTH(8)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .a(a), .b(b), .c(c),
    .z(z), .x(x), .Done(Done), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  a, b, c;
    logic [7:0]  exp_z;
    logic [15:0] exp_x;
    bit          scramble;
    bit          noise_start;
  } job_t;

  job_t jobs[5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Runs one job from IDLE: accept, count cycles to Done, check hold of old
  // results before S3 and new results at Done, then check return to IDLE.
  task automatic run_job(input job_t j);
    logic [7:0]  prev_z;
    logic [15:0] prev_x;
    int cyc;
    @(negedge Clk);
    prev_z = z;
    prev_x = x;
    a = j.a; b = j.b; c = j.c; Start = 1'b1;
    @(posedge Clk);
    cyc = 0;
    while (1) begin
      @(negedge Clk);
      cyc++;
      if (Done || cyc >= 12) break;
      check("busy_in_job", int'(Busy), 1);
      check("z_hold_before_s3", int'(z), int'(prev_z));
      check("x_hold_before_s3", int'(x), int'(prev_x));
      Start = j.noise_start ? cyc[0] : 1'b0;
      if (j.scramble) begin
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      end
    end
    Start = 1'b0;
    check("done_latency", cyc, 4);
    check("z_result", int'(z), int'(j.exp_z));
    check("x_result", int'(x), int'(j.exp_x));
    check("busy_in_done", int'(Busy), 1);
    $display("job a=%0d b=%0d c=%0d -> z=%0d x=%0d latency=%0d", j.a, j.b, j.c, z, x, cyc);
    for (int k = 0; k < 2; k++) begin
      @(negedge Clk);
      check("idle_done", int'(Done), 0);
      check("idle_busy", int'(Busy), 0);
      check("z_hold_after", int'(z), int'(j.exp_z));
      check("x_hold_after", int'(x), int'(j.exp_x));
    end
  endtask

  initial begin
    int cyc;
    int done_at[$];

    jobs[0] = '{a:8'd10,  b:8'd20,  c:8'd5,  exp_z:8'd30,  exp_x:16'd20,    scramble:0, noise_start:0};
    jobs[1] = '{a:8'd200, b:8'd100, c:8'd50, exp_z:8'd250, exp_x:16'd9956,  scramble:0, noise_start:0};
    jobs[2] = '{a:8'd7,   b:8'd9,   c:8'd9,  exp_z:8'd16,  exp_x:16'd47,    scramble:0, noise_start:0};
    jobs[3] = '{a:8'd3,   b:8'd10,  c:8'd1,  exp_z:8'd13,  exp_x:16'd65526, scramble:1, noise_start:0};
    jobs[4] = '{a:8'd10,  b:8'd20,  c:8'd5,  exp_z:8'd30,  exp_x:16'd20,    scramble:1, noise_start:1};

    // Reset with Start and all-ones operands pending.
    @(negedge Clk);
    Rst = 1'b1; Start = 1'b1; a = 8'hFF; b = 8'hFF; c = 8'hFF;
    repeat (2) @(negedge Clk);
    check("rst_z", int'(z), 0);
    check("rst_x", int'(x), 0);
    check("rst_done", int'(Done), 0);
    check("rst_busy", int'(Busy), 0);
    Rst = 1'b0; Start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check("post_rst_idle_busy", int'(Busy), 0);
    end
    $display("reset: z=%0d x=%0d Done=%0d Busy=%0d", z, x, Done, Busy);

    foreach (jobs[i]) run_job(jobs[i]);

    // Back-to-back with Start held high: second job picks up operands at its own accept.
    @(negedge Clk);
    a = 8'd10; b = 8'd20; c = 8'd5; Start = 1'b1;
    @(posedge Clk);
    cyc = 0;
    while (cyc < 14) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 1) begin a = 8'd3; b = 8'd10; c = 8'd1; end
      if (Done) begin
        done_at.push_back(cyc);
        if (done_at.size() == 1) begin
          check("b2b_z1", int'(z), 30);
          check("b2b_x1", int'(x), 20);
        end else begin
          check("b2b_z2", int'(z), 13);
          check("b2b_x2", int'(x), 65526);
          Start = 1'b0;
          break;
        end
      end
    end
    check("b2b_done_count", done_at.size(), 2);
    if (done_at.size() == 2) begin
      check("b2b_first_latency", done_at[0], 4);
      check("b2b_spacing", done_at[1] - done_at[0], 5);
    end
    Start = 1'b0;
    $display("back-to-back: done pulses=%0d z=%0d x=%0d", done_at.size(), z, x);
    repeat (2) @(negedge Clk);
    check("b2b_idle_busy", int'(Busy), 0);

    // Reset while in S2 aborts the job.
    @(negedge Clk);
    a = 8'd10; b = 8'd20; c = 8'd5; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    check("midrst_in_s2_busy", int'(Busy), 1);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("midrst_busy", int'(Busy), 0);
    check("midrst_done", int'(Done), 0);
    check("midrst_z", int'(z), 0);
    check("midrst_x", int'(x), 0);
    cyc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      if (Done) cyc++;
    end
    check("midrst_no_done", cyc, 0);
    $display("mid-job reset: z=%0d x=%0d Busy=%0d stray_done=%0d", z, x, Busy, cyc);
    run_job(jobs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/circuit1_seq_ctrl.md
# circuit1_seq_ctrl

Multicycle, resource-shared implementation of the circuit1 computation (z = max-select of a+b / a+c, x = a*c − (a+b)). A Moore FSM sequences one shared adder/subtractor, one multiplier and one comparator across four cycles under a Start/Done handshake. It sits where the combinational circuit1 datapath would be instantiated when area, not latency, is the constraint.

## Interface
- DATAWIDTH, 8, width of a, b, c, z; x is 2*DATAWIDTH wide
- Clk  input  1  clock, all state updates on rising edge
- Rst  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only in IDLE
- a, b, c  input  DATAWIDTH  unsigned operands; sampled only on the accepting edge
- z  output  DATAWIDTH  registered result: (d > e) ? d : e
- x  output  2*DATAWIDTH  registered result: f − d
- Done  output  1  one-cycle pulse, results valid
- Busy  output  1  high in every state except IDLE

## Operation
- All arithmetic unsigned, modulo result width.
- d = (a + b) mod 2^DATAWIDTH; e = (a + c) mod 2^DATAWIDTH.
- g = d > e (strict); d == e selects e.
- f = a * c, full 2*DATAWIDTH product (operands zero-extended).
- x = (f − zero-extended d) mod 2^(2*DATAWIDTH); underflow wraps, no flag.
- Internal registers: ra, rb, rc (DATAWIDTH), d, e (DATAWIDTH), f (2*DATAWIDTH), z, x.
- Exactly one ALU (add/sub, 2*DATAWIDTH wide), one multiplier, one comparator; ALU used at most once per state.
- States and schedule:
  - IDLE: Busy=0. If Start=1: ra/rb/rc <= a/b/c, go S1; else stay.
  - S1: ALU d <= ra+rb; MUL f <= ra*rc; go S2.
  - S2: ALU e <= ra+rc; go S3.
  - S3: ALU x <= f − d; COMP/MUX z <= (d > e) ? d : e; go DONE.
  - DONE: Done=1; go IDLE unconditionally.
- Start is ignored in S1, S2, S3, DONE (no queuing); a new request needs Start high in IDLE.
- Start held high continuously: new job accepted on the edge leaving IDLE each time, i.e. one job per 5 cycles.
- z, x hold their value from S3 until the next job's S3 (or reset); they do not change in IDLE/S1/S2.
- Input changes after the accepting edge have no effect on the running job.

## Timing
- Reset (Rst=1 at rising edge): state IDLE; z=0, x=0, Done=0, Busy=0; ra, rb, rc, d, e, f = 0. Overrides all other activity.
- Reset mid-job (any state): job aborted, no Done pulse, outputs cleared to 0 on that edge.
- Done, Busy decoded from state register only (Moore, no combinational path from Start).
- Start accepted on edge T0 (in IDLE) -> S1 during T0..T1, S2 T1..T2, S3 T2..T3, DONE T3..T4: Done high for exactly the cycle after edge T3; z/x valid from edge T3 onward.
- Latency Start-accept to Done: 4 cycles; initiation interval 5 cycles.
- Busy high from edge T0 through edge T4 (includes DONE cycle).
- Rst and Start both high on same edge: reset wins, Start lost.

## Test plan
- Reset: Rst=1 two cycles with Start=1, a=b=c=0xFF -> z=0, x=0, Done=0, Busy=0; state stays IDLE after release with Start=0.
- Basic: a=10, b=20, c=5, Start pulse -> Done exactly 4 cycles after accept edge, z=30, x=20; z/x hold after Done while Start=0.
- Wrap and select-e: a=200, b=100, c=50 -> d=44, e=250, z=250, x=9956; tie case a=7, b=9, c=9 -> z=16, x=47.
- Subtract underflow: a=3, b=10, c=1 -> z=13, x=65526; change a/b/c every cycle after accept -> results unchanged.
- Back-to-back: Start held high, jobs (10,20,5) then (3,10,1) -> Done pulses 5 cycles apart, second z/x = 13/65526; Start pulses during S1–DONE produce no extra job.
- Reset mid-job: assert Rst in S2 of job (10,20,5) -> no Done, z=0, x=0, Busy=0 next cycle; fresh Start then completes normally with z=30, x=20.
